i2s_rx_quad: RTL and testbench

- Multi-lane I2S master receiver feeding the ANC input handshake stage.
- Generates one shared SCK/WS pair from a programmable divider and deserializes LANES serial data lines (error, reference, audio, step-size mics) in lockstep.
- Presents one bundled LANES×DW word per frame on a valid/ready interface.
- Replaces four independent receivers plus merge, which guarantees sample alignment across channels.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_rx_quad_if.sv | 18 +
 rtl/i2s_sck_gen.sv | 68 ++++++
 rtl/i2s_rx_quad.sv | 121 ++++++++++++
 tb/tb_i2s_rx_quad.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the multi-lane I2S receiver.
//   I2S_SLOT       SCK cycles per channel slot
//   I2S_FRAME      SCK cycles per frame (left + right slot)
//   I2S_DW         captured bits per lane per frame
//   I2S_MIN_PERIOD smallest usable SCK half-period in clk cycles
//   lane_word_t    one captured lane sample (two's complement audio)
package i2s_pkg;

    localparam int unsigned I2S_SLOT       = 32;
    localparam int unsigned I2S_FRAME      = 2 * I2S_SLOT;
    localparam int unsigned I2S_DW         = 16;
    localparam int unsigned I2S_MIN_PERIOD = 2;

    typedef logic signed [I2S_DW-1:0] lane_word_t;

endpackage

// File: rtl/i2s_rx_quad_if.sv
// Bundled-sample output channel of the I2S receiver.
//   dout      LANES*DW bundled word, lane i at [i*DW +: DW]
//   dout_vld  word valid, held until accepted
//   dout_rdy  consumer ready
// master = receiver side, slave = consumer side.
interface i2s_rx_quad_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 16
);

    logic [LANES*DW-1:0] dout;
    logic                dout_vld;
    logic                dout_rdy;

    modport master (output dout, output dout_vld, input dout_rdy);
    modport slave  (input dout, input dout_vld, output dout_rdy);

endinterface

// File: rtl/i2s_sck_gen.sv
// SCK generator: programmable divider producing the I2S bit clock plus
// single-clk rise/fall strobes marking the cycle in which sck toggles.
//   clk, rst    core clock, asynchronous active-high reset
//   en          enable; low holds the divider idle with sck low
//   sck_period  clk cycles per SCK half-period (0 and 1 act as 2)
//   sck         bit clock
//   rise, fall  strobes, high in the cycle whose closing edge moves sck 0->1 / 1->0
module i2s_sck_gen
    import i2s_pkg::*;
#(
    parameter int unsigned PER_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PER_W-1:0] sck_period,
    output logic             sck,
    output logic             rise,
    output logic             fall
);

    logic [PER_W-1:0] div_q, div_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] per_clamped;
    logic             sck_q, sck_d;
    logic             term;

    always_comb begin
        per_clamped = (sck_period < PER_W'(I2S_MIN_PERIOD)) ? PER_W'(I2S_MIN_PERIOD)
                                                            : sck_period;
        term   = (div_q == per_q - PER_W'(1));
        div_d  = div_q;
        per_d  = per_q;
        sck_d  = sck_q;
        rise   = 1'b0;
        fall   = 1'b0;
        if (!en) begin
            // Idle counts as sitting at reload, so the period in force when
            // en rises is the one presented just before.
            div_d = '0;
            sck_d = 1'b0;
            per_d = per_clamped;
        end else if (term) begin
            div_d = '0;
            sck_d = ~sck_q;
            per_d = per_clamped;
            rise  = ~sck_q;
            fall  = sck_q;
        end else begin
            div_d = div_q + PER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            per_q <= PER_W'(I2S_MIN_PERIOD);
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            per_q <= per_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/i2s_rx_quad.sv
// Multi-lane I2S master receiver. One shared SCK/WS pair clocks LANES serial
// inputs in lockstep; the left-slot word of every lane is captured MSB first
// (one-bit I2S delay) and presented as one bundled word per frame.
//   clk, rst    core clock, asynchronous active-high reset
//   en          receiver enable; low parks the serial side at a frame boundary
//   sck_period  clk cycles per SCK half-period (0 and 1 act as 2)
//   sck, ws     I2S bit clock and word select (ws=0 is the left slot)
//   sd          serial data, one bit per lane
//   dout_if     bundled output word with valid/ready
//   ovf_cnt     saturating count of words dropped under backpressure
module i2s_rx_quad
    import i2s_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = I2S_DW,
    parameter int unsigned SLOT  = I2S_SLOT,
    parameter int unsigned PER_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [PER_W-1:0]     sck_period,
    output logic                 sck,
    output logic                 ws,
    input  logic [LANES-1:0]     sd,
    i2s_rx_quad_if.master        dout_if,
    output logic [7:0]           ovf_cnt
);

    localparam int unsigned FRAME = 2 * SLOT;
    localparam int unsigned CNT_W = $clog2(FRAME);

    logic                        rise, fall;
    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic                        ws_q, ws_d;
    logic [LANES-1:0][DW-1:0]    shreg_q, shreg_d;
    logic [LANES*DW-1:0]         dout_q, dout_d;
    logic                        vld_q, vld_d;
    logic [7:0]                  ovf_q, ovf_d;
    logic                        capture_bit;
    logic                        word_done;

    i2s_sck_gen #(
        .PER_W (PER_W)
    ) u_sck_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sck_period (sck_period),
        .sck        (sck),
        .rise       (rise),
        .fall       (fall)
    );

    // Bit 0 of the slot is the I2S delay bit; bits 1..DW carry the word.
    assign capture_bit = (bit_cnt_q >= CNT_W'(1)) && (bit_cnt_q <= CNT_W'(DW));
    assign word_done   = rise && (bit_cnt_q == CNT_W'(DW));

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        ws_d      = ws_q;
        shreg_d   = shreg_q;
        if (!en) begin
            bit_cnt_d = CNT_W'(FRAME - 1);
            ws_d      = 1'b1;
            shreg_d   = '0;
        end else begin
            if (fall) begin
                bit_cnt_d = (bit_cnt_q == CNT_W'(FRAME - 1)) ? '0 : bit_cnt_q + CNT_W'(1);
                ws_d      = (bit_cnt_d >= CNT_W'(SLOT));
            end
            if (rise && capture_bit) begin
                for (int i = 0; i < LANES; i++) begin
                    shreg_d[i] = {shreg_q[i][DW-2:0], sd[i]};
                end
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        vld_d  = vld_q;
        ovf_d  = ovf_q;
        if (vld_q && dout_if.dout_rdy) begin
            vld_d = 1'b0;
        end
        if (word_done) begin
            // Load the post-shift value so the final bit lands in this word.
            if (!vld_q || dout_if.dout_rdy) begin
                dout_d = shreg_d;
                vld_d  = 1'b1;
            end else if (ovf_q != 8'hFF) begin
                ovf_d = ovf_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= CNT_W'(FRAME - 1);
            ws_q      <= 1'b1;
            shreg_q   <= '0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            ovf_q     <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            ws_q      <= ws_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ws               = ws_q;
    assign dout_if.dout     = dout_q;
    assign dout_if.dout_vld = vld_q;
    assign ovf_cnt          = ovf_q;

endmodule

// File: tb/tb_i2s_rx_quad.sv
// Self-checking bench for i2s_rx_quad. A frame-level reference model derives
// sck/ws, word completion times and the valid/ready/overflow outcome from the
// number of enabled clk edges and the divider period; the bench also acts as
// the four microphones, driving sd from per-frame random word tables.
module tb_i2s_rx_quad;
    import i2s_pkg::*;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = I2S_DW;
    localparam int unsigned SLOT  = I2S_SLOT;
    localparam int unsigned FRAME = I2S_FRAME;
    localparam int unsigned PER_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [PER_W-1:0] sck_period;
    logic             sck;
    logic             ws;
    logic [LANES-1:0] sd;
    logic [7:0]       ovf_cnt;

    i2s_rx_quad_if #(.LANES(LANES), .DW(DW)) bus ();

    i2s_rx_quad #(
        .LANES (LANES),
        .DW    (DW),
        .SLOT  (SLOT),
        .PER_W (PER_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sck_period (sck_period),
        .sck        (sck),
        .ws         (ws),
        .sd         (sd),
        .dout_if    (bus),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int unsigned k;          // enabled clk edges since en rose
    int unsigned p_m;        // effective half-period
    bit          en_m;
    bit          rdy_m;
    bit          vld_m;
    logic [63:0] dout_m;
    int unsigned ovf_m;
    bit          sck_chk;
    lane_word_t  lw [8][4];  // left-slot words per frame/lane
    lane_word_t  rw [8][4];  // right-slot words (must be ignored)

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Edge index at which the word of frame n becomes valid: sck toggle number
    // 2*(DW+1)+1 is the rise that samples bit DW of the first frame.
    function automatic int unsigned kc(input int unsigned n, input int unsigned p);
        return (2 * (DW + 1) + 1 + 2 * FRAME * n) * p;
    endfunction

    function automatic logic [63:0] pack(input int unsigned fr);
        logic [63:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = lw[fr % 8][i];
        return r;
    endfunction

    // Bit position within the frame after kk enabled edges (63 before the first fall).
    function automatic int unsigned bc_of(input int unsigned kk, input int unsigned pp);
        int unsigned f;
        f = kk / (2 * pp);
        return (f == 0) ? FRAME - 1 : (f - 1) % FRAME;
    endfunction

    task automatic fill_words(input bit fixed);
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < LANES; i++) begin
                lw[f][i] = lane_word_t'($urandom);
                rw[f][i] = lane_word_t'($urandom);
                if (fixed) rw[f][i] = 16'hAAAA;
            end
            if (fixed) begin
                lw[f][0] = 16'h1234;
                lw[f][1] = 16'h8001;
                lw[f][2] = 16'hFFFF;
                lw[f][3] = 16'h0000;
            end
        end
    endtask

    task automatic model_edge();
        int unsigned t, m, fr;
        bit cmp, old;
        cmp = 1'b0;
        fr  = 0;
        if (!en_m) begin
            k = 0;
        end else begin
            k++;
            if (k % p_m == 0) begin
                t = k / p_m;
                if (t % 2 == 1 && t >= 3) begin
                    m = (t - 1) / 2;
                    if ((m - 1) % FRAME == DW) begin
                        cmp = 1'b1;
                        fr  = (m - 1) / FRAME;
                    end
                end
            end
        end
        old = vld_m;
        if (old && rdy_m) vld_m = 1'b0;
        if (cmp) begin
            if (!old || rdy_m) begin
                vld_m  = 1'b1;
                dout_m = pack(fr);
            end else if (ovf_m < 255) begin
                ovf_m++;
            end
        end
    endtask

    task automatic drive_sd();
        int unsigned bc, fr;
        bc = bc_of(k, p_m);
        fr = (k / (2 * p_m) == 0) ? 0 : ((k / (2 * p_m)) - 1) / FRAME;
        for (int i = 0; i < LANES; i++) begin
            logic [15:0] w;
            if (bc >= 1 && bc <= DW) begin
                w = lw[fr % 8][i];
                sd[i] = w[DW - bc];
            end else if (bc >= SLOT + 1 && bc <= SLOT + DW) begin
                w = rw[fr % 8][i];
                sd[i] = w[SLOT + DW - bc];
            end else begin
                sd[i] = 1'($urandom);
            end
        end
    endtask

    task automatic tick();
        int unsigned f;
        logic sck_e, ws_e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        f     = k / (2 * p_m);
        sck_e = ((k / p_m) % 2) == 1;
        ws_e  = (f == 0) ? 1'b1 : (bc_of(k, p_m) >= SLOT);
        if (sck_chk) begin
            check("sck", sck, sck_e);
            check("ws", ws, ws_e);
        end
        check("dout_vld", bus.dout_vld, vld_m);
        if (vld_m) check("dout", bus.dout, dout_m);
        check("ovf_cnt", ovf_cnt, ovf_m[7:0]);
        drive_sd();
    endtask

    task automatic set_rdy(input int mode);
        int unsigned x;
        bit r;
        x = k + 1;
        case (mode)
            0: r = 1'b1;
            1: r = (x > kc(2, p_m) + 10);
            2: r = (x % p_m == 0) && (x / p_m >= kc(1, 1)) && ((x / p_m - kc(0, 1)) % (2 * FRAME) == 0);
            default: r = ($urandom_range(0, 3) != 0);
        endcase
        rdy_m        = r;
        bus.dout_rdy = r;
    endtask

    task automatic start(input int unsigned per);
        sck_period = PER_W'(per);
        p_m        = (per < 2) ? 2 : per;
        tick();
        en   = 1'b1;
        en_m = 1'b1;
    endtask

    task automatic steps(input int unsigned n, input int mode);
        for (int unsigned e = 0; e < n; e++) begin
            set_rdy(mode);
            tick();
        end
    endtask

    task automatic stop();
        en   = 1'b0;
        en_m = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic sck_reload_exp(input int unsigned kk);
        if (kk < 4) return 1'b0;
        if (kk < 8) return 1'b1;
        if (kk < 14) return 1'b0;
        if (kk < 20) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int unsigned ovf_before;
        int unsigned per;
        rst          = 1'b1;
        en           = 1'b0;
        sck_period   = 8'd4;
        bus.dout_rdy = 1'b0;
        sd           = '0;
        k = 0; p_m = 4; en_m = 0; rdy_m = 0; vld_m = 0; dout_m = '0; ovf_m = 0;
        sck_chk = 1'b1;
        fill_words(1'b0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_sck", sck, 1'b0);
        check("rst_ws", ws, 1'b1);
        check("rst_vld", bus.dout_vld, 1'b0);
        check("rst_dout", bus.dout, 64'h0);
        check("rst_ovf", ovf_cnt, 8'd0);
        rst = 1'b0;

        // Lane capture with the fixed words, always ready
        fill_words(1'b1);
        start(4);
        steps(700, 0);
        check("lane_word", bus.dout, 64'h0000_FFFF_8001_1234);
        stop();

        // Backpressure: three frames unaccepted, then release
        fill_words(1'b0);
        start(4);
        steps(kc(2, 4) + 5, 1);
        check("bp_ovf", ovf_cnt, 8'd2);
        check("bp_hold", bus.dout, pack(0));
        steps(kc(3, 4) + 20 - k, 1);
        check("bp_frame4", bus.dout, pack(3));
        stop();

        // Accept exactly in the completion cycle
        fill_words(1'b0);
        ovf_before = ovf_m;
        start(3);
        steps(kc(1, 3), 2);
        check("simul_vld", bus.dout_vld, 1'b1);
        check("simul_ovf", ovf_cnt, 8'(ovf_before));
        check("simul_dout", bus.dout, pack(1));
        steps(kc(2, 3) + 5 - k, 2);
        check("simul_dout2", bus.dout, pack(2));
        stop();

        // Divider clamp
        fill_words(1'b0);
        start(0);
        steps(400, 0);
        stop();
        start(1);
        steps(400, 0);
        stop();

        // Period change mid half-period applies at the next reload
        start(4);
        sck_chk = 1'b0;
        steps(6, 0);
        sck_period = 8'd6;
        for (int i = 0; i < 14; i++) begin
            steps(1, 0);
            check("sck_reload", sck, sck_reload_exp(k));
        end
        sck_chk = 1'b1;
        stop();

        // Randomized sessions
        for (int r = 0; r < 2; r++) begin
            fill_words(1'b0);
            per = $urandom_range(0, 5);
            start(per);
            steps(3 * 2 * FRAME * p_m, 3);
            stop();
        end

        // Stop at bit 8 of the second frame with a word pending
        fill_words(1'b0);
        start(2);
        steps(293, 1);
        en   = 1'b0;
        en_m = 1'b0;
        tick();
        check("stop_sck", sck, 1'b0);
        check("stop_ws", ws, 1'b1);
        check("stop_vld", bus.dout_vld, 1'b1);
        tick();
        fill_words(1'b0);
        start(2);
        steps(400, 0);
        stop();

        // Asynchronous reset mid-frame with a pending word
        fill_words(1'b0);
        start(3);
        steps(kc(0, 3) + 30, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_sck", sck, 1'b0);
        check("arst_ws", ws, 1'b1);
        check("arst_vld", bus.dout_vld, 1'b0);
        check("arst_dout", bus.dout, 64'h0);
        check("arst_ovf", ovf_cnt, 8'd0);
        en = 1'b0; en_m = 1'b0; vld_m = 1'b0; dout_m = '0; ovf_m = 0; k = 0;
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
